// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS main controller:
//   - opcode constants for the supported instruction classes
//   - FSM state encoding (exported on the debug 'state' port)
//   - encodings of the alu_src_b, alu_op and pc_src mux selects
//   - the packed control word produced by the output decoder
//   - is_legal_op(): true for every opcode the controller sequences
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQEX  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JEX    = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    SRCB_B       = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_t;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    pc_src_t    pc_src;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec
// Combinational control-word decode for the multicycle MIPS controller.
// Ports:
//   state     in   current FSM state
//   zero      in   ALU zero flag (qualifies the branch PC load)
//   mem_ready in   memory handshake (qualifies the fetch PC/IR load)
//   ctrl      out  packed control word; every field not named for a
//                  state stays 0, including for the unused encodings 12-15
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   zero,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        // PC+4 and the instruction are captured only when the read completes
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while decoding
        ctrl.alu_src_b = SRCB_IMM_SH2;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        // Held high through stalls; the memory commits on its ready cycle
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_RTEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        // Mealy term: take the branch only when A-B is zero this cycle
        ctrl.pc_en     = zero;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JEX: begin
        ctrl.pc_src = PCSRC_JUMP;
        ctrl.pc_en  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Main control FSM of the multicycle MIPS datapath.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   op                opcode from the instruction register
//   zero, mem_ready   ALU zero flag and memory completion handshake
//   pc_en .. pc_src   datapath mux selects and write enables
//   illegal_op        one-cycle pulse in DECODE for unsupported opcodes
//   instr_count       retired-instruction counter, wraps modulo 2^CNT_W
//   state             current FSM state for debug
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  state_t           state_q;
  state_t           state_d;
  logic             illegal_dec;
  logic             retire;
  logic [CNT_W-1:0] count_q;
  ctrl_t            ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = S_FETCH;
    illegal_dec = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            state_d     = S_FETCH;
            illegal_dec = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTEX:   state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_BEQEX:  state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JEX:    state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // An instruction retires on the edge that leaves its last state;
  // a store only leaves MEMWR once the memory has accepted it.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_RTWB, S_BEQEX, S_ADDIWB, S_JEX: retire = 1'b1;
      S_MEMWR: retire = mem_ready;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  mips_ctrl_outdec u_outdec (
    .state     (state_q),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // State-changing strobes are suppressed while reset is held so an
  // abandoned instruction cannot write anything on the reset edge.
  assign pc_en      = ctrl.pc_en     & ~rst;
  assign ir_write   = ctrl.ir_write  & ~rst;
  assign reg_write  = ctrl.reg_write & ~rst;
  assign mem_write  = ctrl.mem_write & ~rst;
  assign illegal_op = illegal_dec    & ~rst;

  assign iord        = ctrl.iord;
  assign mem_read    = ctrl.mem_read;
  assign reg_dst     = ctrl.reg_dst;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign alu_src_a   = ctrl.alu_src_a;
  assign alu_src_b   = ctrl.alu_src_b;
  assign alu_op      = ctrl.alu_op;
  assign pc_src      = ctrl.pc_src;
  assign instr_count = count_q;
  assign state       = state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences the shared PC register, instruction/data memory port, register file and ALU across the fetch, decode, execute, memory and writeback steps. It drives mux selects and write enables from the opcode, the ALU zero flag and a memory ready handshake. A separate ALU decoder consumes alu_op.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
op  in  6  opcode, instr[31:26], from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
pc_en  out  1  PC register load enable
iord  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
reg_dst  out  1  write-reg select: 0=rt, 1=rd
mem_to_reg  out  1  writeback select: 0=ALUOut, 1=MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
alu_op  out  2  00=add, 01=sub, 10=funct-decoded
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
illegal_op  out  1  one-cycle pulse on unsupported opcode
instr_count  out  CNT_W  retired-instruction count
state  out  4  current state, debug

Behaviour:
- Reset: when rst=1 at a clock edge, state becomes FETCH and instr_count becomes 0.
  - While rst=1, pc_en, ir_write, reg_write, mem_write and illegal_op are forced to 0 combinationally.
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - RTEX=6, RTWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11
- Outputs are Moore-decoded from state, except where noted. Any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write=pc_en=mem_ready.
  - Holds in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> RTEX
    - 000100 (beq) -> BEQEX
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JEX
    - any other op -> FETCH, with illegal_op=1 in this DECODE cycle; not counted as retired.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD if op=lw, else MEMWR.
- MEMRD: iord=1, mem_read=1. Holds until mem_ready=1, then MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, then FETCH.
- MEMWR: iord=1, mem_write=1. Holds until mem_ready=1, then FETCH.
  - mem_write is asserted on every hold cycle; memory commits only on the mem_ready cycle.
- RTEX: alu_src_a=1, alu_src_b=00, alu_op=10, then RTWB.
- RTWB: reg_dst=1, mem_to_reg=0, reg_write=1, then FETCH.
- BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero (Mealy on zero), then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00, then ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, then FETCH.
- JEX: pc_src=10, pc_en=1, then FETCH.
- Latency with mem_ready tied to 1:
  - lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.
  - Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Retirement: instr_count increments by 1 on the final-state edge of each legal instruction.
  - Final states are MEMWB, MEMWR (with mem_ready=1), RTWB, BEQEX, ADDIWB and JEX.
  - The counter wraps from all-ones to 0.
- Reset mid-instruction (any state, including a MEMRD/MEMWR stall): the instruction is abandoned, with no partial write after the reset edge, and the next cycle is FETCH.
- Unreachable encodings 12-15 go to FETCH with all strobes 0.

Decomposition:
- Package mips_ctrl_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), state encoding, and the alu_src_b, pc_src and alu_op encodings.
- One natural sub-module: mips_ctrl_outdec, the combinational state+zero+mem_ready -> control-word decode.
- Next-state logic and instr_count stay in the top module.

Test Plan:
- rst=1 for 2 cycles, then released with op=lw and mem_ready=1 -> state sequence 0,1,2,3,4; reg_write=1 and mem_to_reg=1 only in state 4; instr_count=1.
- sw with mem_ready low for 3 cycles in MEMWR -> mem_write high for 4 cycles; count increments once, only on the mem_ready cycle; total 7 cycles.
- beq with zero=1, then beq with zero=0 -> pc_en=1 with pc_src=01 in BEQEX for the first; pc_en=0 for the second; both retire (count +2).
- R-type, addi and j back-to-back, mem_ready=1 -> lengths 4, 4 and 3 cycles; reg_dst=1 only in RTWB; pc_src=10 with pc_en=1 in JEX.
- op=111111 -> illegal_op pulses 1 cycle in DECODE; next state FETCH; instr_count unchanged.
- rst asserted during a MEMRD stall -> no reg_write ever asserted; state=FETCH the following cycle; instr_count=0.
